// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - batch accumulator for results of a 3-bit ripple adder
//
// Sums NUM_OPS operands {Cout,S} (0..14) into an ACC_W-bit wrapping total,
// then presents the total until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   S, Cout    upstream adder result, operand = {Cout,S}
//   in_valid   operand valid            in_ready   operand accepted (not DONE)
//   out_valid  batch total on ACC       out_ready  consumer takes the total
//   ACC        running / final total    OVF        sticky overflow for the batch
//   COUNT      operands accepted in the current batch
module sum_accumulator #(
    parameter int NUM_OPS = 4,
    parameter int ACC_W   = 6,
    localparam int CNT_W  = $clog2(NUM_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       S,
    input  logic             Cout,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] ACC,
    output logic             OVF,
    output logic [CNT_W-1:0] COUNT
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // COUNT value holding the last operand of a batch before it is accepted
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OPS - 1);

    logic [1:0]     state;
    logic [ACC_W:0] operand;
    logic [ACC_W:0] sum;

    // One extra bit on the adder so the wrap-around can be flagged
    assign operand = (ACC_W + 1)'({Cout, S});
    assign sum     = {1'b0, ACC} + operand;

    // Moore handshake outputs
    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ACC   <= '0;
            COUNT <= '0;
            OVF   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ACC   <= operand[ACC_W-1:0];
                        COUNT <= CNT_W'(1);
                        OVF   <= 1'b0;
                        state <= (NUM_OPS == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        ACC   <= sum[ACC_W-1:0];
                        COUNT <= COUNT + CNT_W'(1);
                        OVF   <= OVF | sum[ACC_W];
                        state <= (COUNT == LAST) ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    // Inputs are ignored here; the batch is cleared only once taken
                    if (out_ready) begin
                        ACC   <= '0;
                        COUNT <= '0;
                        OVF   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - self-checking bench for sum_accumulator
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] S;
    logic       Cout;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready6, out_valid6, OVF6;
    logic [5:0] ACC6;
    logic [2:0] COUNT6;

    logic       in_ready4, out_valid4, OVF4;
    logic [3:0] ACC4;
    logic [2:0] COUNT4;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: the batch is just a running true sum and an operand count
    int total = 0;
    int cnt   = 0;
    bit done  = 1'b0;

    always #5 clk = ~clk;

    sum_accumulator #(.NUM_OPS(4), .ACC_W(6)) dut6 (
        .clk(clk), .rst(rst), .S(S), .Cout(Cout),
        .in_valid(in_valid), .in_ready(in_ready6),
        .out_valid(out_valid6), .out_ready(out_ready),
        .ACC(ACC6), .OVF(OVF6), .COUNT(COUNT6)
    );

    sum_accumulator #(.NUM_OPS(4), .ACC_W(4)) dut4 (
        .clk(clk), .rst(rst), .S(S), .Cout(Cout),
        .in_valid(in_valid), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_ready(out_ready),
        .ACC(ACC4), .OVF(OVF4), .COUNT(COUNT4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("acc6",   32'(ACC6),       32'(total % 64));
        check("ovf6",   32'(OVF6),       32'(total >= 64));
        check("count6", 32'(COUNT6),     32'(cnt));
        check("valid6", 32'(out_valid6), 32'(done));
        check("ready6", 32'(in_ready6),  32'(!done));
        check("acc4",   32'(ACC4),       32'(total % 16));
        check("ovf4",   32'(OVF4),       32'(total >= 16));
        check("count4", 32'(COUNT4),     32'(cnt));
        check("valid4", 32'(out_valid4), 32'(done));
        check("ready4", 32'(in_ready4),  32'(!done));
    endtask

    // Advance one clock, apply the batch rules to the model, then compare
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            total = 0; cnt = 0; done = 1'b0;
        end else if (done) begin
            if (out_ready) begin
                total = 0; cnt = 0; done = 1'b0;
            end
        end else if (in_valid) begin
            total += int'({Cout, S});
            cnt++;
            if (cnt == 4) done = 1'b1;
        end
        #1;
        check_all();
    endtask

    task automatic step(input bit r, input bit v, input int op, input bit ordy);
        logic [3:0] opv;
        opv       = op[3:0];
        rst       = r;
        in_valid  = v;
        {Cout, S} = opv;
        out_ready = ordy;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; S = 3'd0; Cout = 1'b0; out_ready = 1'b0;

        // Reset with a valid operand present
        step(1'b1, 1'b1, 14, 1'b0);
        step(1'b1, 1'b1, 14, 1'b0);
        check("rst_acc",   32'(ACC6),      32'd0);
        check("rst_ready", 32'(in_ready6), 32'd1);

        // Back-to-back batch
        step(1'b0, 1'b1, 3, 1'b0);
        step(1'b0, 1'b1, 5, 1'b0);
        step(1'b0, 1'b1, 7, 1'b0);
        step(1'b0, 1'b1, 14, 1'b0);
        check("b2b_acc6",  32'(ACC6),       32'd29);
        check("b2b_ovf6",  32'(OVF6),       32'd0);
        check("b2b_valid", 32'(out_valid6), 32'd1);
        check("b2b_ready", 32'(in_ready6),  32'd0);
        check("b2b_acc4",  32'(ACC4),       32'd13);
        check("b2b_ovf4",  32'(OVF4),       32'd1);

        // Backpressure with inputs offered during DONE
        repeat (5) step(1'b0, 1'b1, int'($urandom_range(0, 14)), 1'b0);
        check("bp_acc6",   32'(ACC6),   32'd29);
        check("bp_count6", 32'(COUNT6), 32'd4);
        step(1'b0, 1'b1, 9, 1'b1);
        check("drain_acc6",   32'(ACC6),      32'd0);
        check("drain_count6", 32'(COUNT6),    32'd0);
        check("drain_ready",  32'(in_ready6), 32'd1);

        // Overflow batch
        repeat (4) step(1'b0, 1'b1, 14, 1'b0);
        check("ovf_acc4", 32'(ACC4), 32'd8);
        check("ovf_ovf4", 32'(OVF4), 32'd1);
        check("ovf_ovf6", 32'(OVF6), 32'd0);
        step(1'b0, 1'b0, 0, 1'b1);
        check("ovf_clear4", 32'(OVF4), 32'd0);

        // Gapped input with garbage operands between transfers
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) check("gap_prevalid", 32'(out_valid6), 32'd0);
            step(1'b0, 1'b1, i, 1'b0);
            if (i < 4) begin
                int gap;
                gap = int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++)
                    step(1'b0, 1'b0, int'($urandom_range(0, 14)), bit'($urandom_range(0, 1)));
            end
        end
        check("gap_acc6",  32'(ACC6),       32'd10);
        check("gap_valid", 32'(out_valid6), 32'd1);
        step(1'b0, 1'b0, 0, 1'b1);

        // Mid-batch reset, then a fresh batch
        step(1'b0, 1'b1, 6, 1'b0);
        step(1'b0, 1'b1, 6, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        check("mid_acc6",   32'(ACC6),   32'd0);
        check("mid_count6", 32'(COUNT6), 32'd0);
        repeat (4) step(1'b0, 1'b1, 1, 1'b0);
        check("mid_new_acc6", 32'(ACC6), 32'd4);

        // Reset while a total is pending in DONE
        step(1'b1, 1'b0, 0, 1'b1);
        check("done_rst_valid", 32'(out_valid6), 32'd0);

        // Random traffic against the model
        repeat (400)
            step(bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 14)), bit'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
